// File: rtl/disp_arb_pkg.sv
// Shared types and constants for the display arbiter.
package disp_arb_pkg;

  localparam int DIGITS  = 6;
  localparam int SEG_W   = 7;
  localparam int FRAME_W = DIGITS * SEG_W;
  localparam int LED_W   = 6;

  localparam logic [FRAME_W-1:0] SEG_BLANK = '0;
  localparam logic [LED_W-1:0]   LED_ALL   = 6'h3F;

  typedef enum logic [1:0] {
    GR_CLOCK  = 2'd0,
    GR_CAL    = 2'd1,
    GR_STATUS = 2'd2,
    GR_ALARM  = 2'd3
  } grant_t;

  // Width of a counter that has to hold values 0 .. n-1 (at least one bit).
  function automatic int cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/brightness_pwm.sv
// Free-running 3-bit brightness PWM; on is high for (level+1) of every 8 cycles.
module brightness_pwm (
  input  logic       CLK,
  input  logic       reset,
  input  logic [2:0] level,
  output logic       on
);

  logic [2:0] pwm_cnt;

  // Counter wraps naturally every 8 cycles.
  always_ff @(posedge CLK) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 3'd1;
  end

  assign on = (pwm_cnt <= level);

endmodule

// File: rtl/display_arbiter.sv
// Display ownership scheduler: picks CLOCK / CAL / STATUS / ALARM, applies
// brightness gating and registers the selected frame onto the display pins.
// Optional build macro DISP_ARB_BLINK_EN: blinks the alarm frame and LEDs.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   GR_CLOCK  | time display; switches to CAL on req_cal once dwell expires
//   GR_CAL    | date display; switches to CLOCK on !req_cal once dwell expires
//   GR_STATUS | overlay; held for HOLD_CYCLES after the last ovl_pulse
//   GR_ALARM  | alarm frame; left on alm_ack or alm_req falling
module display_arbiter
  import disp_arb_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned MIN_DWELL   = 1_000_000,
  parameter int unsigned BLINK_HALF  = 25_000_000
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [FRAME_W-1:0] seg_clk,
  input  logic [FRAME_W-1:0] seg_cal,
  input  logic [FRAME_W-1:0] seg_stat,
  input  logic [FRAME_W-1:0] seg_alm,
  input  logic [LED_W-1:0]   led_cal,
  input  logic               req_cal,
  input  logic               ovl_pulse,
  input  logic               alm_req,
  input  logic               alm_ack,
  input  logic [2:0]         level,
  output logic [FRAME_W-1:0] seg_out,
  output logic [LED_W-1:0]   led_out,
  output logic [1:0]         grant,
  output logic               alm_active
);

  localparam int HOLD_W  = cnt_w(HOLD_CYCLES);
  localparam int DWELL_W = cnt_w(MIN_DWELL);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(MIN_DWELL - 1);

  grant_t              grant_q;
  grant_t              grant_d;
  grant_t              home;
  logic                preempt;
  logic                hold_load;
  logic                dwell_zero;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [DWELL_W-1:0]  dwell_cnt;
  logic                alm_mask;
  logic                pwm_on;
  logic                blink_off;
  logic [FRAME_W-1:0]  frame_mux;
  logic [LED_W-1:0]    led_mux;

  assign dwell_zero = (dwell_cnt == '0);

  // Next-state selection: alarm preempts, overlay next, then home/dwell rules.
  always_comb begin
    grant_d   = grant_q;
    home      = req_cal ? GR_CAL : GR_CLOCK;
    preempt   = alm_req && !alm_mask;
    hold_load = 1'b0;
    case (grant_q)
      GR_CLOCK: begin
        if (preempt)                     grant_d = GR_ALARM;
        else if (ovl_pulse)              grant_d = GR_STATUS;
        else if (req_cal && dwell_zero)  grant_d = GR_CAL;
      end
      GR_CAL: begin
        if (preempt)                     grant_d = GR_ALARM;
        else if (ovl_pulse)              grant_d = GR_STATUS;
        else if (!req_cal && dwell_zero) grant_d = GR_CLOCK;
      end
      GR_STATUS: begin
        if (preempt)                     grant_d = GR_ALARM;
        else if (ovl_pulse)              grant_d = GR_STATUS;
        else if (hold_cnt == '0)         grant_d = home;
      end
      GR_ALARM: begin
        // An ovl_pulse here is deliberately ignored and not remembered.
        if (alm_ack || !alm_req)         grant_d = home;
      end
      default:                           grant_d = GR_CLOCK;
    endcase
    hold_load = ovl_pulse && !preempt && (grant_q != GR_ALARM);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) grant_q <= GR_CLOCK;
    else       grant_q <= grant_d;
  end

  // Overlay hold timer: reloaded by each accepted pulse, counts down in STATUS.
  always_ff @(posedge CLK) begin
    if (reset)                                      hold_cnt <= '0;
    else if (hold_load)                             hold_cnt <= HOLD_LOAD;
    else if (grant_q == GR_STATUS && hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);
  end

  // Dwell timer: reloaded on every state change, saturates at zero.
  always_ff @(posedge CLK) begin
    if (reset)                   dwell_cnt <= '0;
    else if (grant_d != grant_q) dwell_cnt <= DWELL_LOAD;
    else if (!dwell_zero)        dwell_cnt <= dwell_cnt - DWELL_W'(1);
  end

  // Alarm mask: set by a dismiss, cleared as soon as the alarm request drops.
  always_ff @(posedge CLK) begin
    if (reset)                                alm_mask <= 1'b0;
    else if (!alm_req)                        alm_mask <= 1'b0;
    else if (grant_q == GR_ALARM && alm_ack)  alm_mask <= 1'b1;
  end

`ifdef DISP_ARB_BLINK_EN
  localparam int BLINK_W = cnt_w(BLINK_HALF);
  localparam logic [BLINK_W-1:0] BLINK_TC = BLINK_W'(BLINK_HALF - 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  // Blink timer restarts visible on ALARM entry, toggles every BLINK_HALF cycles.
  always_ff @(posedge CLK) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (grant_d == GR_ALARM && grant_q != GR_ALARM) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (grant_q == GR_ALARM) begin
      if (blink_cnt == BLINK_TC) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  assign blink_off = blink_phase && (grant_q == GR_ALARM);
`else
  assign blink_off = 1'b0;
`endif

  brightness_pwm u_pwm (
    .CLK   (CLK),
    .reset (reset),
    .level (level),
    .on    (pwm_on)
  );

  // Frame source for the current owner, gated by brightness and blink.
  always_comb begin
    frame_mux = seg_clk;
    led_mux   = led_cal;
    case (grant_q)
      GR_CLOCK:  begin frame_mux = seg_clk;  led_mux = led_cal; end
      GR_CAL:    begin frame_mux = seg_cal;  led_mux = led_cal; end
      GR_STATUS: begin frame_mux = seg_stat; led_mux = '0;      end
      GR_ALARM:  begin frame_mux = seg_alm;  led_mux = LED_ALL; end
      default:   begin frame_mux = SEG_BLANK; led_mux = '0;     end
    endcase
    if (!pwm_on || blink_off) begin
      frame_mux = SEG_BLANK;
      led_mux   = '0;
    end
  end

  // Output register driving the display pins.
  always_ff @(posedge CLK) begin
    if (reset) begin
      seg_out <= SEG_BLANK;
      led_out <= '0;
    end else begin
      seg_out <= frame_mux;
      led_out <= led_mux;
    end
  end

  assign grant      = grant_q;
  assign alm_active = (grant_q == GR_ALARM);

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter; honours DISP_ARB_BLINK_EN if defined.
module tb_display_arbiter;

  logic        CLK = 1'b0;
  logic        reset;
  logic [41:0] seg_clk, seg_cal, seg_stat, seg_alm;
  logic [5:0]  led_cal;
  logic        req_cal, ovl_pulse, alm_req, alm_ack;
  logic [2:0]  level;
  logic [41:0] seg_out;
  logic [5:0]  led_out;
  logic [1:0]  grant;
  logic        alm_active;

  display_arbiter #(
    .HOLD_CYCLES (8),
    .MIN_DWELL   (4),
    .BLINK_HALF  (3)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .seg_clk    (seg_clk),
    .seg_cal    (seg_cal),
    .seg_stat   (seg_stat),
    .seg_alm    (seg_alm),
    .led_cal    (led_cal),
    .req_cal    (req_cal),
    .ovl_pulse  (ovl_pulse),
    .alm_req    (alm_req),
    .alm_ack    (alm_ack),
    .level      (level),
    .seg_out    (seg_out),
    .led_out    (led_out),
    .grant      (grant),
    .alm_active (alm_active)
  );

  always #5 CLK = ~CLK;

  localparam int G = 0, S = 1, L = 2, A = 3;

  typedef struct {
    int          cyc;
    string       tag;
    int          sel;
    logic [41:0] val;
  } sb_t;

  sb_t sb[$];
  int  cyc_n    = 0;
  int  n_checks = 0;
  int  n_errors = 0;

  always @(posedge CLK) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [41:0] obs, input logic [41:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  // Queue an expectation dc edges from now, keeping the queue in cycle order.
  task automatic push(input int dc, input string tag, input int sel, input logic [41:0] val);
    sb_t e;
    int  i;
    e.cyc = cyc_n + dc;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
    sb.insert(i, e);
  endtask

  function automatic logic [41:0] observe(input int sel);
    case (sel)
      G:       return {40'b0, grant};
      S:       return seg_out;
      L:       return {36'b0, led_out};
      default: return {41'b0, alm_active};
    endcase
  endfunction

  // Compare every expectation that falls due on this cycle.
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
      sb_t e;
      e = sb.pop_front();
      chk(e.tag, observe(e.sel), e.val);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  logic        blink_en;
  logic [41:0] alm_off_seg;
  logic [41:0] alm_off_led;
  int          n_on, n_off, n_zero;

  initial begin
`ifdef DISP_ARB_BLINK_EN
    blink_en = 1'b1;
`else
    blink_en = 1'b0;
`endif
    alm_off_seg = blink_en ? 42'h0 : 42'h3F_0F0F_0F0F;
    alm_off_led = blink_en ? 42'h0 : 42'h3F;

    reset = 1'b1; req_cal = 1'b0; ovl_pulse = 1'b0; alm_req = 1'b0; alm_ack = 1'b0;
    level    = 3'd7;
    seg_clk  = 42'h11_1111_1111;
    seg_cal  = 42'h22_2222_2222;
    seg_stat = 42'h33_3333_3333;
    seg_alm  = 42'h3F_0F0F_0F0F;
    led_cal  = 6'h15;

    // Reset state
    push(1, "rst_grant", G, 0);
    push(2, "rst_grant2", G, 0);
    push(2, "rst_seg", S, 0);
    push(2, "rst_led", L, 0);
    push(2, "rst_alm_active", A, 0);
    tick(3);
    reset = 1'b0;
    push(2, "idle_seg", S, seg_clk);
    push(2, "idle_led", L, {36'b0, led_cal});
    push(2, "idle_grant", G, 0);
    tick(3);

    // First CLOCK->CAL switch is immediate
    req_cal = 1'b1;
    push(1, "cal_grant", G, 1);
    push(2, "cal_seg", S, seg_cal);
    tick(2);

    // Dwell: request back to CLOCK one cycle after CAL entry
    req_cal = 1'b0;
    push(0, "dwell_hold_a", G, 1);
    push(2, "dwell_hold_b", G, 1);
    push(3, "dwell_switch", G, 0);
    push(4, "dwell_seg", S, seg_clk);
    tick(6);

    // Single overlay: 8 cycles of STATUS
    ovl_pulse = 1'b1; tick(1); ovl_pulse = 1'b0;
    push(0, "ovl_first", G, 2);
    push(7, "ovl_last", G, 2);
    push(8, "ovl_home", G, 0);
    push(1, "ovl_seg", S, seg_stat);
    push(1, "ovl_led", L, 0);
    push(9, "ovl_seg_home", S, seg_clk);
    tick(12);

    // Overlay extended by a second pulse in its 5th cycle: 13 cycles
    ovl_pulse = 1'b1; tick(1); ovl_pulse = 1'b0;
    tick(4);
    push(0, "ovl2_c5", G, 2);
    ovl_pulse = 1'b1; tick(1); ovl_pulse = 1'b0;
    push(3, "ovl2_c9", G, 2);
    push(7, "ovl2_c13", G, 2);
    push(8, "ovl2_home", G, 0);
    tick(10);

    // Alarm preempts an overlay
    ovl_pulse = 1'b1; tick(1); ovl_pulse = 1'b0;
    tick(2);
    alm_req = 1'b1;
    push(1, "alm_grant", G, 3);
    push(1, "alm_active", A, 1);
    tick(1);
    push(1, "alm_seg_e1", S, seg_alm);
    push(1, "alm_led_e1", L, 42'h3F);
    push(3, "alm_seg_e3", S, seg_alm);
    push(4, "alm_seg_e4", S, alm_off_seg);
    push(4, "alm_led_e4", L, alm_off_led);
    push(6, "alm_seg_e6", S, alm_off_seg);
    push(7, "alm_seg_e7", S, seg_alm);
    push(7, "alm_led_e7", L, 42'h3F);
    tick(8);

    // Dismiss with a simultaneous overlay pulse: goes home, pulse lost
    alm_ack = 1'b1; ovl_pulse = 1'b1; tick(1); alm_ack = 1'b0; ovl_pulse = 1'b0;
    push(0, "ack_home", G, 0);
    push(0, "ack_alm_inactive", A, 0);
    push(2, "ack_no_ovl", G, 0);
    push(4, "mask_hold", G, 0);
    tick(5);

    // Request low then high again re-enters ALARM
    alm_req = 1'b0; tick(1); alm_req = 1'b1;
    push(0, "rearm_low", G, 0);
    push(1, "rearm_alarm", G, 3);
    tick(3);

    // Alarm request falling exits to home, here CAL
    alm_req = 1'b0; req_cal = 1'b1;
    push(1, "fall_home_cal", G, 1);
    tick(6);

    // Alarm and overlay together: alarm wins, pulse dropped
    alm_req = 1'b1; ovl_pulse = 1'b1; tick(1); ovl_pulse = 1'b0; alm_req = 1'b0;
    push(0, "alm_over_ovl", G, 3);
    push(1, "ovl_dropped", G, 1);
    tick(4);

    // Brightness: level 2 gives 3 of 8 cycles on
    level = 3'd2;
    tick(2);
    n_on = 0; n_off = 0;
    repeat (8) begin
      @(negedge CLK);
      if (seg_out == seg_cal) n_on++;
      else if (seg_out == 42'h0) n_off++;
    end
    chk("pwm_l2_on", 42'(n_on), 42'd3);
    chk("pwm_l2_off", 42'(n_off), 42'd5);

    // Full brightness never blanks
    level = 3'd7;
    tick(2);
    n_zero = 0;
    repeat (16) begin
      @(negedge CLK);
      if (seg_out == 42'h0) n_zero++;
    end
    chk("pwm_l7_zero", 42'(n_zero), 42'd0);

    tick(3);
    chk("sb_drain", 42'(sb.size()), 42'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
# display_arbiter

Owns the six-digit seven-segment display and six-LED bar and shares them among four sources: clock time, calendar date, the status overlay (12/24 and brightness), and an alarm. A four-state scheduler picks the owner using fixed priority, a minimum dwell time and a timed overlay. A brightness PWM then gates the selected frame, which is registered onto the display pins. It sits between the clock/calendar display selectors and the top-level d1..d6/led outputs, replacing the sel/sel2 muxing and the per-output brightness gating.

## Interface
- HOLD_CYCLES, 50_000_000: number of cycles the status overlay stays up after its last request.
- MIN_DWELL, 1_000_000: minimum number of cycles the display stays on CLOCK or CAL before switching between them.
- BLINK_HALF, 25_000_000: half-period of the alarm blink, in cycles.
- CLK  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- seg_clk, seg_cal, seg_stat, seg_alm  in  42 each  source frames {d1,d2,d3,d4,d5,d6}; d1 = [41:35].
- led_cal  in  6  weekday LED pattern.
- req_cal  in  1  level: the user has selected calendar view.
- ovl_pulse  in  1  one-cycle request to show the status overlay.
- alm_req  in  1  level: alarm condition.
- alm_ack  in  1  one-cycle alarm dismiss.
- level  in  3  brightness, 0 (dimmest) to 7 (full).
- seg_out  out  42  registered display frame.
- led_out  out  6  registered LED bar.
- grant  out  2  current owner: 0 CLOCK, 1 CAL, 2 STATUS, 3 ALARM.
- alm_active  out  1  high while in ALARM.

## Operation
- State register (grant), with states CLOCK, CAL, STATUS and ALARM.
- "Home" means CAL if req_cal is high, otherwise CLOCK.
- Preemption (any state):
  - If alm_req=1 and alm_mask=0, the next state is ALARM.
  - ALARM is not subject to the dwell timer.
- ALARM exits:
  - On alm_ack: set alm_mask and go Home.
  - On alm_req falling: go Home.
  - alm_mask clears on the first cycle alm_req=0.
- Overlay:
  - ovl_pulse in CLOCK, CAL or STATUS goes to (or stays in) STATUS and loads hold_cnt = HOLD_CYCLES-1.
  - In STATUS, hold_cnt decrements each cycle; when it reads 0 the next state is Home.
  - ovl_pulse in ALARM is dropped and does not queue.
- CLOCK↔CAL: follows req_cal, but only when dwell_cnt = 0.
- dwell_cnt:
  - Loaded with MIN_DWELL-1 on every state entry.
  - Decrements toward 0 and saturates there.
- Frame source per state:
  - CLOCK: seg_clk; led = led_cal.
  - CAL: seg_cal; led = led_cal.
  - STATUS: seg_stat; led = 0.
  - ALARM: seg_alm; led = 6'h3F.
- Brightness:
  - 3-bit pwm_cnt runs freely, incrementing every cycle.
  - on = (pwm_cnt <= level), giving a duty of (level+1)/8.
  - Frame and LED are ANDed with on.
- Simultaneous events:
  - alm_req with ovl_pulse: ALARM wins and the pulse is lost.
  - alm_ack with ovl_pulse while in ALARM: go Home; the pulse is lost.
  - STATUS expiry with req_cal change: Home is evaluated in that cycle.
- Reset values:
  - grant = CLOCK.
  - seg_out = 0, led_out = 0, alm_active = 0.
  - hold_cnt, dwell_cnt, pwm_cnt, blink counter and alm_mask = 0.
  - Because dwell_cnt resets to 0, the first CLOCK→CAL switch is not delayed.
  - A reset asserted mid-overlay or mid-alarm aborts it immediately.

## Timing
- Requests are sampled at edge n; grant changes at edge n+1.
- seg_out/led_out reflect the new owner at edge n+2: the output register samples the mux of the current grant and the current pwm on.
- alm_active is combinationally equal to (grant == ALARM).
- The overlay is visible for exactly HOLD_CYCLES cycles of grant=STATUS after its last ovl_pulse.
- The dwell counter guarantees at least MIN_DWELL cycles between CLOCK/CAL switches.

## Configuration
- DISP_ARB_BLINK_EN defined:
  - In ALARM, blink_cnt counts to BLINK_HALF-1, then toggles the phase.
  - blink_cnt and phase reset to 0 on ALARM entry, so the frame starts visible.
  - Phase 1 blanks both the frame and the LEDs.
- DISP_ARB_BLINK_EN undefined:
  - The alarm frame is steady and no blink counter is built.
  - BLINK_HALF is ignored.

## Structure
- Package disp_arb_pkg holds:
  - The grant_t enum (2-bit, with the encodings above).
  - DIGITS = 6, SEG_W = 7, FRAME_W = 42.
  - SEG_BLANK = 42'b0 and LED_ALL = 6'h3F.
- One sub-module, brightness_pwm: the 3-bit counter plus compare, producing the on signal.
- The FSM, counters and output register stay in display_arbiter.

## Test plan
Bench parameters: HOLD_CYCLES=8, MIN_DWELL=4, BLINK_HALF=3, level=7 unless stated.
- Reset, then idle:
  - grant=0 and seg_out=0 during reset.
  - seg_out=seg_clk two cycles after reset drops.
  - req_cal=1 gives grant=1 at the next edge (dwell starts at 0).
- Dwell:
  - Toggle req_cal 1→0 one cycle after entering CAL.
  - grant stays 1 until 4 cycles after entry, then becomes 0.
- Overlay:
  - A single ovl_pulse gives grant=2 for exactly 8 cycles, then Home.
  - A second pulse at cycle 5 extends STATUS to 13 cycles total.
- Alarm preempt and ack:
  - alm_req=1 during STATUS gives grant=3 with the overlay abandoned.
  - alm_ack gives Home, and grant stays there while alm_req stays 1.
  - alm_req 0 then 1 re-enters ALARM.
- Brightness:
  - With level=2, over 8 consecutive cycles seg_out equals the source frame on 3 cycles and 0 on 5.
  - With level=7, seg_out is never 0.
- Blink (DISP_ARB_BLINK_EN defined):
  - In ALARM, seg_out alternates seg_alm/0 every 3 cycles.
  - led_out alternates 3F/00 in step.
  - With the macro undefined, both outputs are steady.
